// File: rtl/oq_rr_scheduler_pkg.sv
// Shared definitions for the output-queue round-robin scheduler:
// FSM encodings, default timing values and the index-width helper.
package oq_rr_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GUARD     = 2'd3
    } oq_state_t;

    localparam int OQ_DEFAULT_GUARD_CYCLES   = 2;
    localparam int OQ_DEFAULT_TIMEOUT_CYCLES = 4096;

    // Ceiling log2, never below 1 so single-entry vectors still get a bit.
    function automatic int oq_log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/oq_rr_scheduler_rr_priority_sel.sv
// Round-robin priority selector: first set bit of `eligible` found by
// searching upward from `rr_ptr`, wrapping at N (exact for any N).
module rr_priority_sel #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] eligible,
    input  logic [W-1:0] rr_ptr,
    output logic         found,
    output logic [W-1:0] index
);

    int j;

    // Scan N positions starting at rr_ptr; the first hit wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= N) j = j - N;
            if (!found && eligible[j]) begin
                found = 1'b1;
                index = j[W-1:0];
            end
        end
    end

endmodule

// File: rtl/oq_rr_scheduler.sv
// Output-queue round-robin scheduler. Picks one eligible queue, hands it
// to the packet remover with a single rd_start pulse, waits for rd_done
// (or a timeout), then holds off for a guard window so the queue flags
// can settle before the next decision.
//
// state        | meaning
// IDLE         | evaluate eligibility, latch the winning queue index
// START        | rd_start high for this one cycle
// WAIT_DONE    | waiting for rd_done, timeout counter running
// GUARD        | flag-settle window, GUARD_CYCLES long
module oq_rr_scheduler
    import oq_rr_scheduler_pkg::*;
#(
    parameter int NUM_OUTPUT_QUEUES = 8,
    parameter int NUM_OQ_WIDTH      = oq_log2(NUM_OUTPUT_QUEUES),
    parameter int GUARD_CYCLES      = OQ_DEFAULT_GUARD_CYCLES,
    parameter int TIMEOUT_CYCLES    = OQ_DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_OUTPUT_QUEUES-1:0] oq_empty,
    input  logic [NUM_OUTPUT_QUEUES-1:0] enable_send_pkt,
    input  logic [NUM_OUTPUT_QUEUES-1:0] out_fifo_full,
    input  logic                         rd_done,
    output logic                         rd_start,
    output logic [NUM_OQ_WIDTH-1:0]      rd_oq,
    output logic                         busy,
    output logic                         timeout_err,
    output logic [31:0]                  num_pkts_scheduled
);

    localparam int TMO_W = oq_log2(TIMEOUT_CYCLES) + 1;
    localparam int GRD_W = oq_log2(GUARD_CYCLES + 1) + 1;
    localparam logic [TMO_W-1:0]        TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GRD_W-1:0]        GRD_LOAD = GRD_W'(GUARD_CYCLES - 1);
    localparam logic [NUM_OQ_WIDTH-1:0] LAST_Q   = NUM_OQ_WIDTH'(NUM_OUTPUT_QUEUES - 1);

    oq_state_t                   state, state_next;
    logic [NUM_OQ_WIDTH-1:0]     rr_ptr, rr_ptr_next;
    logic [NUM_OQ_WIDTH-1:0]     rd_oq_next;
    logic [NUM_OQ_WIDTH-1:0]     done_ptr;
    logic [TMO_W-1:0]            tmo_cnt, tmo_cnt_next;
    logic [GRD_W-1:0]            grd_cnt, grd_cnt_next;
    logic                        rd_start_next;
    logic                        busy_next;
    logic                        timeout_err_next;
    logic [31:0]                 pkts_next;
    logic [NUM_OUTPUT_QUEUES-1:0] eligible;
    logic                        sel_found;
    logic [NUM_OQ_WIDTH-1:0]     sel_index;

    assign eligible = ~oq_empty & enable_send_pkt & ~out_fifo_full;
    assign done_ptr = (rd_oq == LAST_Q) ? '0 : rd_oq + 1'b1;

    rr_priority_sel #(
        .N (NUM_OUTPUT_QUEUES),
        .W (NUM_OQ_WIDTH)
    ) u_sel (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .found    (sel_found),
        .index    (sel_index)
    );

    // Next-state and next-output logic; outputs are registered from these.
    always_comb begin
        state_next       = state;
        rr_ptr_next      = rr_ptr;
        rd_oq_next       = rd_oq;
        tmo_cnt_next     = tmo_cnt;
        grd_cnt_next     = grd_cnt;
        timeout_err_next = timeout_err;
        pkts_next        = num_pkts_scheduled;
        case (state)
            ST_IDLE: begin
                if (sel_found) begin
                    rd_oq_next = sel_index;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                pkts_next    = num_pkts_scheduled + 32'd1;
                tmo_cnt_next = '0;
                state_next   = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // A done in the expiry cycle wins and is a normal completion.
                if (rd_done) begin
                    rr_ptr_next  = done_ptr;
                    grd_cnt_next = GRD_LOAD;
                    state_next   = ST_GUARD;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout_err_next = 1'b1;
                    rr_ptr_next      = done_ptr;
                    grd_cnt_next     = GRD_LOAD;
                    state_next       = ST_GUARD;
                end else begin
                    tmo_cnt_next = tmo_cnt + 1'b1;
                end
            end
            ST_GUARD: begin
                if (grd_cnt == '0) state_next = ST_IDLE;
                else               grd_cnt_next = grd_cnt - 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
        rd_start_next = (state_next == ST_START);
        busy_next     = (state_next != ST_IDLE);
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= ST_IDLE;
            rr_ptr             <= '0;
            rd_oq              <= '0;
            tmo_cnt            <= '0;
            grd_cnt            <= '0;
            rd_start           <= 1'b0;
            busy               <= 1'b0;
            timeout_err        <= 1'b0;
            num_pkts_scheduled <= '0;
        end else begin
            state              <= state_next;
            rr_ptr             <= rr_ptr_next;
            rd_oq              <= rd_oq_next;
            tmo_cnt            <= tmo_cnt_next;
            grd_cnt            <= grd_cnt_next;
            rd_start           <= rd_start_next;
            busy               <= busy_next;
            timeout_err        <= timeout_err_next;
            num_pkts_scheduled <= pkts_next;
        end
    end

endmodule

// File: tb/tb_oq_rr_scheduler.sv
// Self-checking bench for oq_rr_scheduler: expected grants come from a
// round-robin reference model and are queued when eligibility is driven.
module tb_oq_rr_scheduler;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] oq_empty = '1;
    logic [N-1:0] enable_send_pkt = '0;
    logic [N-1:0] out_fifo_full = '0;
    logic         rd_done = 1'b0;
    logic         rd_start;
    logic [2:0]   rd_oq;
    logic         busy;
    logic         timeout_err;
    logic [31:0]  num_pkts_scheduled;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_q[$];
    int m_ptr = 0;
    int exp_pkts = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    oq_rr_scheduler dut (
        .clk                (clk),
        .reset              (reset),
        .oq_empty           (oq_empty),
        .enable_send_pkt    (enable_send_pkt),
        .out_fifo_full      (out_fifo_full),
        .rd_done            (rd_done),
        .rd_start           (rd_start),
        .rd_oq              (rd_oq),
        .busy               (busy),
        .timeout_err        (timeout_err),
        .num_pkts_scheduled (num_pkts_scheduled)
    );

    function automatic int model_pick(input logic [N-1:0] e, input int p);
        for (int i = 0; i < N; i++) begin
            int j;
            j = (p + i) % N;
            if (e[j]) return j;
        end
        return -1;
    endfunction

    task automatic set_elig(input logic [N-1:0] e);
        oq_empty        = ~e;
        enable_send_pkt = e;
        out_fifo_full   = '0;
    endtask

    task automatic push_grants(input logic [N-1:0] e, input int count);
        for (int k = 0; k < count; k++) begin
            int p;
            p = model_pick(e, m_ptr);
            exp_q.push_back(p);
            m_ptr = (p + 1) % N;
            exp_pkts++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_elig('0);
        rd_done = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        m_ptr = 0;
        exp_pkts = 0;
    endtask

    // Wait (bounded) for rd_start, compare rd_oq with the scoreboard, and
    // optionally return rd_done the cycle after the start.
    task automatic grant(input string name, input bit do_done, output int at);
        bit found;
        int ev;
        logic [2:0] ev3;
        found = 1'b0;
        at = -1;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (rd_start === 1'b1) begin
                found = 1'b1;
                at = cyc;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL %s: no rd_start within 64 cycles (got none, required one)", name);
        end else if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: unexpected rd_start rd_oq=%0d, required no grant", name, rd_oq);
        end else begin
            ev = exp_q.pop_front();
            ev3 = ev[2:0];
            if (rd_oq !== ev3) begin
                failures++;
                $display("FAIL %s: rd_oq got %0d required %0d", name, rd_oq, ev3);
            end
        end
        if (do_done) begin
            @(negedge clk) rd_done = 1'b1;
            @(negedge clk) rd_done = 1'b0;
        end
    endtask

    task automatic check_no_start(input string name, input int ncyc);
        int seen;
        seen = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (rd_start !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL %s: rd_start pulses got %0d required 0", name, seen);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks += 5;
        if (rd_start !== 1'b0) begin failures++; $display("FAIL reset_rd_start: got %b required 0", rd_start); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
        if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err: got %b required 0", timeout_err); end
        if (num_pkts_scheduled !== 32'd0) begin failures++; $display("FAIL reset_pkts: got %0d required 0", num_pkts_scheduled); end
        if (rd_oq !== 3'd0) begin failures++; $display("FAIL reset_rd_oq: got %0d required 0", rd_oq); end
        // rd_done while idle must be ignored
        rd_done = 1'b1;
        @(negedge clk) rd_done = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL idle_done_busy: got %b required 0", busy); end
    endtask

    task automatic test_rr_sequence();
        int at, prev;
        prev = -1;
        set_elig(8'b0010_1001);
        push_grants(8'b0010_1001, 5);
        for (int k = 0; k < 5; k++) begin
            grant("rr_seq", 1'b1, at);
            if (k == 4) set_elig('0);
            if (k > 0) begin
                checks++;
                if (at - prev != 5) begin
                    failures++;
                    $display("FAIL rr_spacing: got %0d cycles required 5", at - prev);
                end
            end
            prev = at;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (num_pkts_scheduled !== 32'(exp_pkts)) begin
            failures++;
            $display("FAIL rr_pkts: got %0d required %0d", num_pkts_scheduled, exp_pkts);
        end
    endtask

    task automatic test_single_q7();
        int at;
        set_elig(8'h80);
        push_grants(8'h80, 3);
        for (int k = 0; k < 3; k++) begin
            grant("q7_only", 1'b1, at);
            if (k == 2) set_elig('0);
        end
        repeat (3) @(negedge clk);
        // pointer must have wrapped to 0: with 0 and 7 eligible, 0 wins
        set_elig(8'h81);
        push_grants(8'h81, 1);
        grant("q7_wrap", 1'b1, at);
        set_elig('0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_fifo_full();
        int at, t0;
        oq_empty        = ~8'h50;
        enable_send_pkt = 8'h50;
        out_fifo_full   = 8'h10;
        push_grants(8'h40, 1);
        grant("full_skip", 1'b1, at);
        oq_empty = ~8'h10;
        check_no_start("full_hold", 10);
        out_fifo_full = '0;
        t0 = cyc;
        push_grants(8'h10, 1);
        grant("full_release", 1'b1, at);
        set_elig('0);
        checks++;
        if (at - t0 != 1) begin
            failures++;
            $display("FAIL full_latency: got %0d cycles required 1", at - t0);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_guard();
        int at;
        set_elig(8'h02);
        push_grants(8'h02, 1);
        grant("guard_grant", 1'b1, at);
        // stale non-empty flag for one more cycle, then the queue reads empty
        @(negedge clk) oq_empty[1] = 1'b1;
        check_no_start("guard_no_regrant", 12);
        set_elig('0);
    endtask

    task automatic test_reset_mid_wait();
        int at;
        set_elig(8'h08);
        push_grants(8'h08, 1);
        grant("rst_grant", 1'b0, at);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        set_elig('0);
        @(negedge clk) reset = 1'b0;
        exp_q.delete();
        m_ptr = 0;
        exp_pkts = 0;
        rd_done = 1'b1;
        @(negedge clk) rd_done = 1'b0;
        check_no_start("rst_no_start", 6);
        checks += 3;
        if (num_pkts_scheduled !== 32'd0) begin failures++; $display("FAIL rst_pkts: got %0d required 0", num_pkts_scheduled); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b required 0", busy); end
        if (timeout_err !== 1'b0) begin failures++; $display("FAIL rst_timeout_err: got %b required 0", timeout_err); end
        set_elig(8'h08);
        push_grants(8'h08, 1);
        grant("rst_fresh_grant", 1'b1, at);
        set_elig('0);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_timeout();
        int at, at2;
        set_elig(8'h04);
        push_grants(8'h04, 2);
        grant("tmo_grant", 1'b0, at);
        repeat (4096) @(negedge clk);
        checks += 2;
        if (timeout_err !== 1'b0) begin failures++; $display("FAIL tmo_early: got %b required 0", timeout_err); end
        if (busy !== 1'b1) begin failures++; $display("FAIL tmo_busy: got %b required 1", busy); end
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b1) begin failures++; $display("FAIL tmo_flag: got %b required 1", timeout_err); end
        grant("tmo_next_grant", 1'b1, at2);
        set_elig('0);
        checks++;
        if (at2 - at != 4100) begin
            failures++;
            $display("FAIL tmo_regrant_time: got %0d cycles required 4100", at2 - at);
        end
        repeat (4) @(negedge clk);
        checks += 2;
        if (timeout_err !== 1'b1) begin failures++; $display("FAIL tmo_sticky: got %b required 1", timeout_err); end
        if (num_pkts_scheduled !== 32'(exp_pkts)) begin
            failures++;
            $display("FAIL tmo_pkts: got %0d required %0d", num_pkts_scheduled, exp_pkts);
        end
    endtask

    task automatic test_done_at_expiry();
        int at;
        do_reset();
        set_elig(8'h20);
        push_grants(8'h20, 1);
        grant("exp_grant", 1'b0, at);
        set_elig('0);
        repeat (4095) @(negedge clk);
        @(negedge clk) rd_done = 1'b1;
        @(negedge clk) rd_done = 1'b0;
        checks += 2;
        if (timeout_err !== 1'b0) begin failures++; $display("FAIL exp_done_err: got %b required 0", timeout_err); end
        if (busy !== 1'b1) begin failures++; $display("FAIL exp_done_guard: got %b required 1", busy); end
        set_elig(8'h21);
        push_grants(8'h21, 1);
        grant("exp_after", 1'b1, at);
        set_elig('0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_rr_sequence();
        test_single_q7();
        test_fifo_full();
        test_guard();
        test_reset_mid_wait();
        test_timeout();
        test_done_at_expiry();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
